// File: rtl/audio_cic_integrator_decim.sv
// -----------------------------------------------------------------------------
// audio_cic_integrator_decim
// Integrator and decimation half of the audio CIC decimator. It runs STAGES
// cascaded wrap-around integrators at the input sample rate. Every RATE
// accepted samples it presents the last integrator value to the sample-rate
// comb stage, together with a one-clock strobe.
//
// Optional feature: define AUDIO_CIC_PHASE_SYNC_EN to add the phase_sync input.
// phase_sync forces the decimation counter to 0 and suppresses cen_out on that
// edge. Left and right channel instances use it to share one decimation phase.
// -----------------------------------------------------------------------------
module audio_cic_integrator_decim #(
    parameter int IW     = 16,   // input sample width (signed)
    parameter int STAGES = 3,    // integrator stages, 1..4
    parameter int RATE   = 8,    // decimation factor, 1..256
    parameter int CALCW  = 25,   // internal and output width
    parameter int DEPTH  = 1,    // downstream comb depth; only the width check uses it
    localparam int PW    = (RATE > 1) ? $clog2(RATE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef AUDIO_CIC_PHASE_SYNC_EN
    input  logic                    phase_sync,
`endif
    input  logic                    cen_in,
    input  logic signed [IW-1:0]    snd_in,
    output logic signed [CALCW-1:0] snd_out,
    output logic                    cen_out,
    output logic [PW-1:0]           phase
);

    // Worst-case growth of the integrator chain seen by the downstream comb.
    localparam int MIN_CALCW = IW + STAGES * $clog2(RATE * DEPTH);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("audio_cic_integrator_decim: STAGES must be 1..4");
        end
        if (RATE < 1 || RATE > 256) begin : g_bad_rate
            $error("audio_cic_integrator_decim: RATE must be 1..256");
        end
        if (CALCW < MIN_CALCW) begin : g_bad_calcw
            $error("audio_cic_integrator_decim: CALCW too narrow for IW, STAGES, RATE and DEPTH");
        end
    endgenerate

    logic signed [CALCW-1:0] integ     [STAGES];
    logic signed [CALCW-1:0] integ_nxt [STAGES];
    logic [PW-1:0]           cnt;
    logic                    last;
    logic                    sync_hit;

`ifdef AUDIO_CIC_PHASE_SYNC_EN
    assign sync_hit = phase_sync;
`else
    assign sync_hit = 1'b0;
`endif

    assign last  = (cnt == PW'(RATE - 1));
    assign phase = cnt;

    // Next integrator values. Each stage after the first adds the value its
    // predecessor held before this update, which makes the cascade pipelined.
    // Modulo-2^CALCW wrap is intended: the comb cancels it.
    always_comb begin
        integ_nxt[0] = integ[0] + CALCW'(snd_in);
        for (int k = 1; k < STAGES; k++) begin
            integ_nxt[k] = integ[k] + integ[k-1];
        end
    end

    // State update: integrators on accepted samples, decimation counter, output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: integ is a small register array, not a RAM, so it can be cleared in reset.
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
            cnt     <= '0;
            snd_out <= '0;
            cen_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the pre-edge values.
            cen_out <= 1'b0;
            if (cen_in) begin
                integ <= integ_nxt;
            end
            if (sync_hit) begin
                cnt <= '0;
            end else if (cen_in) begin
                if (last) begin
                    cnt     <= '0;
                    snd_out <= integ_nxt[STAGES-1];
                    cen_out <= 1'b1;
                end else begin
                    cnt <= cnt + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_cic_integrator_decim.sv
// -----------------------------------------------------------------------------
// tb_audio_cic_integrator_decim
// Four DUT configurations share one input stream:
//   c0: STAGES=3 RATE=8 CALCW=25   c1: STAGES=1 RATE=4 CALCW=18
//   c2: STAGES=2 RATE=4 CALCW=20   c3: STAGES=3 RATE=1 CALCW=25
// The reference model keeps every sample accepted since reset. It derives the
// last integrator value in closed form: with a pipelined cascade, stage k after
// n samples equals sum_j x_j * C(n-j, k). Decimation is tracked as a count of
// accepted samples modulo RATE.
// -----------------------------------------------------------------------------
module tb_audio_cic_integrator_decim;

    logic        clk = 1'b0;
    logic        reset;
    logic        cen_in;
    logic [15:0] snd_in;
`ifdef AUDIO_CIC_PHASE_SYNC_EN
    logic        phase_sync;
`endif

    logic [24:0] snd0; logic cen0; logic [2:0] ph0;
    logic [17:0] snd1; logic cen1; logic [1:0] ph1;
    logic [19:0] snd2; logic cen2; logic [1:0] ph2;
    logic [24:0] snd3; logic cen3; logic [0:0] ph3;

    always #5 clk = ~clk;

    audio_cic_integrator_decim #(.IW(16), .STAGES(3), .RATE(8), .CALCW(25)) u_c0 (
        .clk(clk), .reset(reset),
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        .phase_sync(phase_sync),
`endif
        .cen_in(cen_in), .snd_in(snd_in), .snd_out(snd0), .cen_out(cen0), .phase(ph0));

    audio_cic_integrator_decim #(.IW(16), .STAGES(1), .RATE(4), .CALCW(18)) u_c1 (
        .clk(clk), .reset(reset),
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        .phase_sync(phase_sync),
`endif
        .cen_in(cen_in), .snd_in(snd_in), .snd_out(snd1), .cen_out(cen1), .phase(ph1));

    audio_cic_integrator_decim #(.IW(16), .STAGES(2), .RATE(4), .CALCW(20)) u_c2 (
        .clk(clk), .reset(reset),
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        .phase_sync(phase_sync),
`endif
        .cen_in(cen_in), .snd_in(snd_in), .snd_out(snd2), .cen_out(cen2), .phase(ph2));

    audio_cic_integrator_decim #(.IW(16), .STAGES(3), .RATE(1), .CALCW(25)) u_c3 (
        .clk(clk), .reset(reset),
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        .phase_sync(phase_sync),
`endif
        .cen_in(cen_in), .snd_in(snd_in), .snd_out(snd3), .cen_out(cen3), .phase(ph3));

    // Configuration table, indexed like the instances above.
    int stg[4] = '{3, 1, 2, 3};
    int rt[4]  = '{8, 4, 4, 1};
    int cw[4]  = '{25, 18, 20, 25};

    // Reference model state.
    longint samples[$];
    int     align[4];
    longint exp_snd[4];
    longint exp_cen[4];
    longint exp_ph[4];

    // Observations collected for the hand-computed checks.
    longint rec1[$], rec2[$], rec3[$], phq1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mask(input longint v, input int w);
        return v & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint binom(input longint m, input int k);
        case (k)
            0:       return 1;
            1:       return m;
            2:       return (m * (m - 1)) / 2;
            default: return (m * (m - 1) * (m - 2)) / 6;
        endcase
    endfunction

    function automatic longint model_value(input int g);
        longint acc = 0;
        int n = samples.size();
        for (int i = 0; i < n; i++) begin
            acc += samples[i] * binom(longint'(n - 1 - i), stg[g] - 1);
        end
        return mask(acc, cw[g]);
    endfunction

    function automatic void model_update(input bit r, input bit c, input logic [15:0] x, input bit ps);
        if (r) begin
            samples.delete();
            for (int g = 0; g < 4; g++) begin
                align[g] = 0; exp_snd[g] = 0; exp_cen[g] = 0; exp_ph[g] = 0;
            end
        end else begin
            if (c) samples.push_back(longint'($signed(x)));
            for (int g = 0; g < 4; g++) begin
                exp_cen[g] = 0;
                if (ps) begin
                    align[g] = 0;
                end else if (c) begin
                    align[g]++;
                    if (align[g] == rt[g]) begin
                        align[g]   = 0;
                        exp_cen[g] = 1;
                        exp_snd[g] = model_value(g);
                    end
                end
                exp_ph[g] = align[g];
            end
        end
    endfunction

    // One clock: drive inputs on the falling edge, let the DUT take them on the
    // rising edge, then compare every output on the next falling edge.
    task automatic step(input bit r, input bit c, input logic [15:0] x, input bit ps);
        reset  = r;
        cen_in = c;
        snd_in = x;
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        phase_sync = ps;
`endif
        model_update(r, c, x, ps);
        @(posedge clk);
        @(negedge clk);
        check("c0 cen_out", longint'(cen0), exp_cen[0]);
        check("c0 snd_out", longint'(snd0), exp_snd[0]);
        check("c0 phase",   longint'(ph0),  exp_ph[0]);
        check("c1 cen_out", longint'(cen1), exp_cen[1]);
        check("c1 snd_out", longint'(snd1), exp_snd[1]);
        check("c1 phase",   longint'(ph1),  exp_ph[1]);
        check("c2 cen_out", longint'(cen2), exp_cen[2]);
        check("c2 snd_out", longint'(snd2), exp_snd[2]);
        check("c2 phase",   longint'(ph2),  exp_ph[2]);
        check("c3 cen_out", longint'(cen3), exp_cen[3]);
        check("c3 snd_out", longint'(snd3), exp_snd[3]);
        check("c3 phase",   longint'(ph3),  exp_ph[3]);
        if (cen1) rec1.push_back(longint'(snd1));
        if (cen2) rec2.push_back(longint'(snd2));
        if (cen3) rec3.push_back(longint'(snd3));
        if (c && !r) phq1.push_back(longint'(ph1));
    endtask

    task automatic clear_recs();
        rec1.delete(); rec2.delete(); rec3.delete(); phq1.delete();
    endtask

    initial begin
        longint prev;
        int     n;
        bit     r, c, ps;
        logic [15:0] x;

        reset  = 1'b1;
        cen_in = 1'b0;
        snd_in = '0;
`ifdef AUDIO_CIC_PHASE_SYNC_EN
        phase_sync = 1'b0;
`endif
        @(negedge clk);

        // Reset takes priority over a sample presented in the same cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd1000, 1'b0);
        check("reset c0 snd_out", longint'(snd0), 0);
        check("reset c0 cen_out", longint'(cen0), 0);
        check("reset c1 phase",   longint'(ph1),  0);

        // DC step: snd_in=1 on every third clock, 12 samples.
        clear_recs();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 16'd1, 1'b0);
            step(1'b0, 1'b0, 16'd1, 1'b0);
            step(1'b0, 1'b0, 16'd1, 1'b0);
        end
        check("dc c1 pulses", longint'(rec1.size()), 3);
        check("dc c1 out#1", rec1[0], 4);
        check("dc c1 out#2", rec1[1], 8);
        check("dc c1 out#3", rec1[2], 12);
        check("dc c1 phase s1", phq1[0], 1);
        check("dc c1 phase s2", phq1[1], 2);
        check("dc c1 phase s3", phq1[2], 3);
        check("dc c1 phase s4", phq1[3], 0);
        check("rate1 c3 pulses", longint'(rec3.size()), 12);
        check("rate1 c3 out#1", rec3[0], 0);
        check("rate1 c3 out#2", rec3[1], 0);
        check("rate1 c3 out#3", rec3[2], 1);
        check("rate1 c3 out#4", rec3[3], 4);
        check("rate1 c3 out#5", rec3[4], 10);
        check("rate1 c3 out#6", rec3[5], 20);

        // Impulse through a two-stage cascade.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        clear_recs();
        step(1'b0, 1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'd0, 1'b0);
        check("impulse c2 pulses", longint'(rec2.size()), 2);
        check("impulse c2 out#1", rec2[0], 3);
        check("impulse c2 out#2", rec2[1], 7);

        // Wrap-around: full-scale DC into an 18-bit single integrator.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        clear_recs();
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 16'd32767, 1'b0);
        check("wrap c1 pulses", longint'(rec1.size()), 16);
        prev = 0;
        foreach (rec1[i]) begin
            check("wrap c1 diff", mask(rec1[i] - prev, 18), 131068);
            prev = rec1[i];
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = (i >= 1200) ? 1'b1 : ($urandom_range(0, 9) < 6);
            x  = 16'($urandom);
            ps = 1'b0;
`ifdef AUDIO_CIC_PHASE_SYNC_EN
            ps = ($urandom_range(0, 49) == 0);
`endif
            step(r, c, x, ps);
        end

`ifdef AUDIO_CIC_PHASE_SYNC_EN
        // Phase sync at phase 5 on the RATE=8 instance.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        n = 0;
        while (ph0 != 3'd5 && n < 20) begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            n++;
        end
        check("sync reach phase 5", longint'(ph0), 5);
        step(1'b0, 1'b1, 16'($urandom), 1'b1);
        check("sync no cen_out", longint'(cen0), 0);
        check("sync phase 0",    longint'(ph0),  0);
        n = 0;
        do begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            n++;
        end while (!cen0 && n < 20);
        check("sync samples to cen_out", longint'(n), 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_cic_integrator_decim.md
Name: audio_cic_integrator_decim

Overview:
- Integrator and decimation half of the audio CIC decimator.
- Accepts high-rate signed samples on a clock-enable strobe and runs STAGES cascaded wrap-around integrators.
- Every RATE input samples, emits the last integrator value with a one-cycle sample strobe.
- The output feeds the sample-rate comb stage directly: snd_out drives the comb's snd_in and cen_out drives the comb's cen; both run at width CALCW.

Parameters:
- IW, 16, input sample width (signed).
- STAGES, 3, number of integrator stages; legal range 1..4.
- RATE, 8, decimation factor; legal range 1..256.
- CALCW, 25, internal and output width. Must be >= IW + STAGES*clog2(RATE*DEPTH), where DEPTH is the downstream comb depth. Elaboration-time assertion on violation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock clk
- cen_in  in  1  input sample strobe, one clk per high-rate sample
- snd_in  in  IW  signed input sample, valid when cen_in=1
- snd_out  out  CALCW  signed decimated integrator output (to comb snd_in)
- cen_out  out  1  one-clk strobe marking a new snd_out (to comb cen)
- phase  out  clog2(RATE) (min 1)  current decimation counter value, for debug and test

Behaviour:
- Reset (reset=1 at a clk edge):
  - all integrators, snd_out, cen_out and the decimation counter clear to 0.
  - reset has priority over cen_in in the same cycle; a sample presented during reset is discarded.
  - Reset mid-operation discards partial accumulation; the first output after reset occurs on the RATE-th accepted sample.
- Input: snd_in sign-extended to CALCW.
- Integrator update, on an edge with cen_in=1 only; no change when cen_in=0:
  - int[0] <= int[0] + sext(snd_in)
  - int[k] <= int[k] + int[k-1] for k >= 1, using the pre-update int[k-1] (pipelined cascade).
- Arithmetic is modulo 2^CALCW two's-complement wrap. No saturation, no overflow flag. Wrap is required for CIC correctness; the downstream comb cancels it.
- Decimation counter cnt:
  - on cen_in, cnt increments; when cnt==RATE-1 it wraps to 0.
  - RATE=1: cnt is held at 0 and every accepted sample produces an output.
- Output:
  - on the cen_in edge where cnt==RATE-1, snd_out <= post-update value of int[STAGES-1], computed combinationally from the next-state value.
  - cen_out <= 1 on that same edge, else 0. cen_out is high for exactly one clk.
  - snd_out holds between strobes.
  - Latency: snd_out/cen_out change on the same clk edge as the decimating cen_in; observable one clk later.
- Input cadence: cen_in may be high on consecutive clks, including continuously high. Throughput is one sample per clk; cen_out is then high every RATE clks.
- No backpressure: the consumer must accept every cen_out pulse.

Optional Feature:
- Macro: AUDIO_CIC_PHASE_SYNC_EN.
- When defined, adds input port phase_sync (1 bit):
  - phase_sync=1 at a clk edge forces cnt to 0 and suppresses any cen_out on that edge. Integrators are unaffected and still accumulate if cen_in=1.
  - Priority order: reset > phase_sync > normal counting.
  - Used to align decimation phase across left/right channel instances.
- When undefined: no port; the counter runs free from reset.

Test Plan:
- DC step: STAGES=1, RATE=4, CALCW=18, snd_in=1 with cen_in every 3rd clk → cen_out pulses after samples 4, 8, 12; snd_out = 4, 8, 12; phase cycles 0,1,2,3.
- Impulse through cascade: STAGES=2, RATE=4, snd_in=1 for sample 1 then 0 → snd_out = 3 at sample 4, 7 at sample 8.
- Wrap-around: IW=16, STAGES=1, RATE=4, CALCW=18, snd_in=32767 held, cen_in continuous for 64 samples:
  - int[0] wraps modulo 2^18.
  - Successive snd_out differences (mod 2^18, signed) always equal 131068.
  - cen_out is high every 4th clk.
- Reset priority: reset=1 with cen_in=1 and snd_in=1000 → all state 0, no cen_out. After release, the first cen_out occurs exactly RATE accepted samples later.
- RATE=1, STAGES=3: snd_in=1 continuous → cen_out high every cen_in clk; snd_out sequence 0, 0, 1, 4, 10, 20 (cascade delay matches pipelined update).
- With AUDIO_CIC_PHASE_SYNC_EN, RATE=8: pulse phase_sync when phase=5 → no cen_out that edge; phase=0 next; the following cen_out occurs after 8 further accepted samples.
